vga_pattern_gen: RTL and testbench

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

---
 rtl/vga_pattern_gen.sv | 185 ++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
//   Streams the active area of a video frame as a valid/ready pixel stream
//   in raster order. The stream can show one of four test patterns.
//
//   Parameters
//     H_VISIBLE    active pixels per line (multiple of 8, >= 8)
//     V_VISIBLE    active lines per frame (>= 1)
//     COLOR_WIDTH  bits per color channel
//
//   Ports
//     clk          rising-edge clock
//     rst          asynchronous active-high reset
//     pattern_sel  requested pattern: 0 bars, 1 gradient, 2 checker, 3 pulse.
//                  It takes effect at the next frame boundary.
//     m_pix_valid  pixel on m_pix_* is valid. It stays high after reset.
//     m_pix_ready  downstream accepts the pixel
//     m_pix_red/grn/blu  pixel color
//     m_pix_sof    pixel is (0,0)
//     m_pix_eol    pixel is the last one of its line
module vga_pattern_gen #(
    parameter int H_VISIBLE   = 640,
    parameter int V_VISIBLE   = 480,
    parameter int COLOR_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             pattern_sel,
    output logic                   m_pix_valid,
    input  logic                   m_pix_ready,
    output logic [COLOR_WIDTH-1:0] m_pix_red,
    output logic [COLOR_WIDTH-1:0] m_pix_grn,
    output logic [COLOR_WIDTH-1:0] m_pix_blu,
    output logic                   m_pix_sof,
    output logic                   m_pix_eol
);

    localparam int BAR_LEN = H_VISIBLE / 8;
    localparam int XW      = (H_VISIBLE > 1) ? $clog2(H_VISIBLE) : 1;
    localparam int YW      = (V_VISIBLE > 1) ? $clog2(V_VISIBLE) : 1;
    localparam int BW      = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;

    localparam logic [XW-1:0] X_LAST   = XW'(H_VISIBLE - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_VISIBLE - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_LEN - 1);

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_GRAD  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_PULSE = 2'd3
    } pattern_e;

    // These registers hold the position of the pixel currently presented.
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [BW-1:0] bar_pix_q, bar_pix_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [7:0]    frame_q, frame_d;
    pattern_e      pat_q, pat_d;

    logic                   xfer;
    logic                   load;
    logic [COLOR_WIDTH-1:0] red_d, grn_d, blu_d;
    logic                   sof_d, eol_d;
    logic                   x_b5, y_b5;

    assign xfer = m_pix_valid & m_pix_ready;
    // A new pixel is loaded on every transfer. A pixel is also loaded on the
    // first edge after reset, when the output register is still empty.
    assign load = xfer | ~m_pix_valid;

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        bar_pix_d = bar_pix_q;
        bar_idx_d = bar_idx_q;
        frame_d   = frame_q;
        pat_d     = pat_q;
        if (xfer) begin
            if (x_q == X_LAST) begin
                x_d       = '0;
                bar_pix_d = '0;
                bar_idx_d = '0;
                if (y_q == Y_LAST) begin
                    y_d     = '0;
                    frame_d = frame_q + 8'd1;
                    pat_d   = pattern_e'(pattern_sel);
                end else begin
                    y_d = y_q + YW'(1);
                end
            end else begin
                x_d = x_q + XW'(1);
                if (bar_pix_q == BAR_LAST) begin
                    bar_pix_d = '0;
                    bar_idx_d = bar_idx_q + 3'd1;
                end else begin
                    bar_pix_d = bar_pix_q + BW'(1);
                end
            end
        end
    end

    // Colors are computed from the next position and registered with it.
    // This keeps the colors, sof and eol aligned on the same pixel.
    assign x_b5 = 1'(x_d >> 5);
    assign y_b5 = 1'(y_d >> 5);

    always_comb begin
        red_d = '0;
        grn_d = '0;
        blu_d = '0;
        case (pat_d)
            PAT_BARS: begin
                // Bar colors follow directly from the bits of the bar index.
                red_d = bar_idx_d[1] ? '0 : '1;
                grn_d = bar_idx_d[2] ? '0 : '1;
                blu_d = bar_idx_d[0] ? '0 : '1;
            end
            PAT_GRAD: begin
                red_d = COLOR_WIDTH'(x_d >> 2);
                grn_d = COLOR_WIDTH'(y_d >> 2);
                blu_d = COLOR_WIDTH'(frame_d);
            end
            PAT_CHECK: begin
                if (x_b5 == y_b5) begin
                    red_d = '1;
                    grn_d = '1;
                    blu_d = '1;
                end
            end
            PAT_PULSE: begin
                red_d = COLOR_WIDTH'(frame_d >> 4);
                grn_d = COLOR_WIDTH'(frame_d >> 4);
                blu_d = COLOR_WIDTH'(frame_d >> 4);
            end
            default: ;
        endcase
    end

    assign sof_d = (x_d == '0) && (y_d == '0);
    assign eol_d = (x_d == X_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q         <= '0;
            y_q         <= '0;
            bar_pix_q   <= '0;
            bar_idx_q   <= '0;
            frame_q     <= '0;
            m_pix_valid <= 1'b0;
            m_pix_red   <= '0;
            m_pix_grn   <= '0;
            m_pix_blu   <= '0;
            m_pix_sof   <= 1'b0;
            m_pix_eol   <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            bar_pix_q <= bar_pix_d;
            bar_idx_q <= bar_idx_d;
            frame_q   <= frame_d;
            if (load) begin
                m_pix_valid <= 1'b1;
                m_pix_red   <= red_d;
                m_pix_grn   <= grn_d;
                m_pix_blu   <= blu_d;
                m_pix_sof   <= sof_d;
                m_pix_eol   <= eol_d;
            end
        end
    end

    // The active pattern follows pattern_sel on every clock edge while reset
    // is held. This load is synchronous so the register has no asynchronous
    // data load. The first pixel after release uses the value from the last
    // reset edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q <= pattern_e'(pattern_sel);
        end else begin
            pat_q <= pat_d;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Testbench for vga_pattern_gen. It uses two instances:
//   dut_a: 16x2 frame. It covers bars, random stalls, pulse over 256+ frames,
//          and a reset in the middle of a frame.
//   dut_b: 640x2 frame. It covers the gradient and a bars to checker switch.
// A reference model derives each pixel from its linear index in the stream.
module tb_vga_pattern_gen;

    localparam int HA = 16;
    localparam int VA = 2;
    localparam int HB = 640;
    localparam int VB = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] psel_a, psel_b;
    logic       rdy_a, rdy_b;
    logic       v_a, sof_a, eol_a, v_b, sof_b, eol_b;
    logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;

    always #5 clk = ~clk;

    vga_pattern_gen #(.H_VISIBLE(HA), .V_VISIBLE(VA), .COLOR_WIDTH(4)) dut_a (
        .clk(clk), .rst(rst), .pattern_sel(psel_a),
        .m_pix_valid(v_a), .m_pix_ready(rdy_a),
        .m_pix_red(r_a), .m_pix_grn(g_a), .m_pix_blu(b_a),
        .m_pix_sof(sof_a), .m_pix_eol(eol_a)
    );

    vga_pattern_gen #(.H_VISIBLE(HB), .V_VISIBLE(VB), .COLOR_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .pattern_sel(psel_b),
        .m_pix_valid(v_b), .m_pix_ready(rdy_b),
        .m_pix_red(r_b), .m_pix_grn(g_b), .m_pix_blu(b_b),
        .m_pix_sof(sof_b), .m_pix_eol(eol_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state per DUT: index of the presented pixel, whether output
    // has started, and the pattern active for the current frame.
    int n_pix[2];
    bit started[2];
    int pat_act[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] ref_rgb(input int pat, input int h, input int x, input int y, input int fr);
        int i;
        logic [3:0] r, g, b;
        case (pat)
            0: begin
                i = x / (h / 8);
                r = (i inside {0, 1, 4, 5}) ? 4'hF : 4'h0;
                g = (i inside {0, 1, 2, 3}) ? 4'hF : 4'h0;
                b = (i inside {0, 2, 4, 6}) ? 4'hF : 4'h0;
            end
            1: begin
                r = 4'((x / 4) % 16);
                g = 4'((y / 4) % 16);
                b = 4'(fr % 16);
            end
            2: begin
                r = (((x / 32) % 2) == ((y / 32) % 2)) ? 4'hF : 4'h0;
                g = r;
                b = r;
            end
            default: begin
                r = 4'((fr / 16) % 16);
                g = r;
                b = r;
            end
        endcase
        return {r, g, b};
    endfunction

    task automatic model_step(input int id, input int h, input int v, input logic rstv,
                              input logic [1:0] psel, input logic valid, input logic rdy,
                              input logic sof, input logic eol,
                              input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        int x, y, fr;
        logic [14:0] got, exp;
        got = {valid, sof, eol, r, g, b};
        if (rstv) begin
            check_eq(id == 0 ? "rst_out_a" : "rst_out_b", 32'(got), 32'd0);
            n_pix[id]   = 0;
            started[id] = 1'b0;
            pat_act[id] = int'(psel);
            return;
        end
        if (!started[id]) begin
            check_eq(id == 0 ? "pre_first_a" : "pre_first_b", 32'(got), 32'd0);
            started[id] = 1'b1;
            return;
        end
        x  = n_pix[id] % h;
        y  = (n_pix[id] / h) % v;
        fr = (n_pix[id] / (h * v)) % 256;
        exp = {1'b1, (x == 0 && y == 0), (x == h - 1), ref_rgb(pat_act[id], h, x, y, fr)};
        check_eq(id == 0 ? "pix_a" : "pix_b", 32'(got), 32'(exp));

        // Directed checks against fixed values.
        if (id == 0 && pat_act[0] == 0) begin
            case (x)
                0, 1:   check_eq("bars_x0_1", 32'({r, g, b}), 32'h0FFF);
                2, 3:   check_eq("bars_x2_3", 32'({r, g, b}), 32'h0FF0);
                14, 15: check_eq("bars_x14_15", 32'({r, g, b}), 32'h0000);
                default: ;
            endcase
        end
        if (id == 0 && pat_act[0] == 3 && x == 0 && y == 0) begin
            if (fr == 15) check_eq("pulse_f15", 32'(r), 32'd0);
            if (fr == 16) check_eq("pulse_f16", 32'(r), 32'd1);
            if (fr == 0)  check_eq("pulse_wrap_f0", 32'(r), 32'd0);
        end
        if (id == 1 && pat_act[1] == 1) begin
            if (x == 4)  check_eq("grad_r_x4", 32'(r), 32'h1);
            if (x == 63) check_eq("grad_r_x63", 32'(r), 32'hF);
            if (x == 64) check_eq("grad_r_x64", 32'(r), 32'h0);
        end
        if (id == 1 && pat_act[1] == 2 && y == 0) begin
            if (x == 0)  check_eq("check_sof_white", 32'({r, g, b}), 32'h0FFF);
            if (x == 32) check_eq("check_x32_black", 32'({r, g, b}), 32'h0000);
        end

        if (valid && rdy) begin
            if (x == h - 1 && y == v - 1) pat_act[id] = int'(psel);
            n_pix[id]++;
        end
    endtask

    // Outputs are sampled on the falling edge. Inputs change 1 time unit
    // after the rising edge.
    always @(negedge clk) begin
        model_step(0, HA, VA, rst, psel_a, v_a, rdy_a, sof_a, eol_a, r_a, g_a, b_a);
        model_step(1, HB, VB, rst, psel_b, v_b, rdy_b, sof_b, eol_b, r_b, g_b, b_b);
    end

    initial begin
        bit found;
        rst    = 1'b1;
        psel_a = 2'd0;
        psel_b = 2'd1;
        rdy_a  = 1'b1;
        rdy_b  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int c = 0; c < 9000; c++) begin
            @(posedge clk);
            #1;
            // dut_a: random stalls at first. After that it sends one pixel
            // per clock.
            rdy_a = (c < 200) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (c == 100) psel_a = 2'd3;
            // dut_b: gradient, then bars, then checker. Each change is made
            // in the middle of a frame.
            if (c == 300)  psel_b = 2'd0;
            if (c == 1580) psel_b = 2'd2;
        end

        // Pulse reset while dut_a presents pixel (5,1).
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(posedge clk);
            #1;
            if (n_pix[0] % (HA * VA) == HA + 5) found = 1'b1;
        end
        if (!found) check_eq("rst_wait_timeout", 32'd0, 32'd1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (80) @(posedge clk);
        @(negedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
